rgb_led_scheduler: RTL and testbench



---
 rtl/rgb_led_scheduler.sv | 184 ++++++++++++++++++
 tb/tb_rgb_led_scheduler.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/rgb_led_scheduler.sv
// Round-robin time-slot sharing of one active-low RGB LED, with per-slot 3-channel PWM and a blank gap.
// Optional macro RGB_LED_SCHED_HEARTBEAT_EN adds an idle green heartbeat from a 32-bit free-running counter.
module rgb_led_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int PWM_BITS    = 8,
  parameter int SLOT_CYCLES = 24000000,
  parameter int GAP_CYCLES  = 2400000,
  parameter int HB_BIT      = 24
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*PWM_BITS-1:0]  duty_r,
  input  logic [NUM_REQ*PWM_BITS-1:0]  duty_g,
  input  logic [NUM_REQ*PWM_BITS-1:0]  duty_b,
  output logic [NUM_REQ-1:0]           grant,
  output logic                         busy,
  output logic                         LED_R,
  output logic                         LED_G,
  output logic                         LED_B
);

  localparam int TMR_MAX = (SLOT_CYCLES > GAP_CYCLES) ? SLOT_CYCLES : GAP_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int PTR_W   = $clog2(NUM_REQ);
  localparam logic [TMR_W-1:0] SLOT_LAST = TMR_W'(SLOT_CYCLES - 1);
  localparam logic [TMR_W-1:0] GAP_LAST  = TMR_W'(GAP_CYCLES - 1);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(NUM_REQ - 1);

  if (NUM_REQ < 2 || NUM_REQ > 8 || SLOT_CYCLES < 2 || GAP_CYCLES < 1 ||
      HB_BIT < 0 || HB_BIT > 31) begin : g_bad_params
    $error("rgb_led_scheduler: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

  state_t              state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic                busy_q, busy_d;
  logic [PTR_W-1:0]    owner_q, owner_d;
  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [PWM_BITS-1:0] duty_r_q, duty_r_d;
  logic [PWM_BITS-1:0] duty_g_q, duty_g_d;
  logic [PWM_BITS-1:0] duty_b_q, duty_b_d;
  logic                led_r_q, led_r_d;
  logic                led_g_q, led_g_d;
  logic                led_b_q, led_b_d;
`ifdef RGB_LED_SCHED_HEARTBEAT_EN
  logic [31:0]         hb_cnt_q, hb_cnt_d;
`endif

  logic [PTR_W-1:0]    win;
  logic [PTR_W-1:0]    next_ptr;
  logic [PWM_BITS-1:0] sel_r, sel_g, sel_b;
  logic                show_on;

  // Scan downward in offset so the nearest set bit at or above the pointer is the last one kept.
  always_comb begin
    win = rr_ptr_q;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      int idx;
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req[PTR_W'(idx)]) win = PTR_W'(idx);
    end
  end

  always_comb begin
    sel_r = '0;
    sel_g = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win == PTR_W'(i)) begin
        sel_r = duty_r[i*PWM_BITS +: PWM_BITS];
        sel_g = duty_g[i*PWM_BITS +: PWM_BITS];
        sel_b = duty_b[i*PWM_BITS +: PWM_BITS];
      end
    end
  end

  assign next_ptr = (owner_q == PTR_LAST) ? '0 : owner_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    owner_d   = owner_q;
    rr_ptr_d  = rr_ptr_q;
    timer_d   = timer_q;
    duty_r_d  = duty_r_q;
    duty_g_d  = duty_g_q;
    duty_b_d  = duty_b_q;
    pwm_cnt_d = pwm_cnt_q + 1'b1;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d  = SHOW;
          grant_d  = NUM_REQ'(1) << win;
          owner_d  = win;
          timer_d  = '0;
          duty_r_d = sel_r;
          duty_g_d = sel_g;
          duty_b_d = sel_b;
        end
      end
      SHOW: begin
        if (timer_q == SLOT_LAST || !req[owner_q]) begin
          state_d  = GAP;
          grant_d  = '0;
          timer_d  = '0;
          rr_ptr_d = next_ptr;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      GAP: begin
        if (timer_q == GAP_LAST) begin
          state_d = IDLE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);

    // LED pins follow the state of the current cycle, so they lag the grant by one clock.
    show_on = (state_q == SHOW);
    led_r_d = ~(show_on && (pwm_cnt_q < duty_r_q));
    led_g_d = ~(show_on && (pwm_cnt_q < duty_g_q));
    led_b_d = ~(show_on && (pwm_cnt_q < duty_b_q));
`ifdef RGB_LED_SCHED_HEARTBEAT_EN
    hb_cnt_d = hb_cnt_q + 32'd1;
    if (state_q == IDLE) led_g_d = ~hb_cnt_q[HB_BIT];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      busy_q    <= 1'b0;
      owner_q   <= '0;
      rr_ptr_q  <= '0;
      timer_q   <= '0;
      pwm_cnt_q <= '0;
      duty_r_q  <= '0;
      duty_g_q  <= '0;
      duty_b_q  <= '0;
      led_r_q   <= 1'b1;
      led_g_q   <= 1'b1;
      led_b_q   <= 1'b1;
`ifdef RGB_LED_SCHED_HEARTBEAT_EN
      hb_cnt_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      busy_q    <= busy_d;
      owner_q   <= owner_d;
      rr_ptr_q  <= rr_ptr_d;
      timer_q   <= timer_d;
      pwm_cnt_q <= pwm_cnt_d;
      duty_r_q  <= duty_r_d;
      duty_g_q  <= duty_g_d;
      duty_b_q  <= duty_b_d;
      led_r_q   <= led_r_d;
      led_g_q   <= led_g_d;
      led_b_q   <= led_b_d;
`ifdef RGB_LED_SCHED_HEARTBEAT_EN
      hb_cnt_q  <= hb_cnt_d;
`endif
    end
  end

  assign grant = grant_q;
  assign busy  = busy_q;
  assign LED_R = led_r_q;
  assign LED_G = led_g_q;
  assign LED_B = led_b_q;

endmodule

// File: tb/tb_rgb_led_scheduler.sv
// Scoreboard bench for rgb_led_scheduler: stimulus queues expected slots, a negedge monitor measures and compares them.
module tb_rgb_led_scheduler;

  localparam int NUM_REQ     = 4;
  localparam int PWM_BITS    = 4;
  localparam int SLOT_CYCLES = 16;
  localparam int GAP_CYCLES  = 4;
  localparam int HB_BIT      = 3;

  logic                        clk = 1'b0;
  logic                        rst;
  logic [NUM_REQ-1:0]          req;
  logic [NUM_REQ*PWM_BITS-1:0] duty_r, duty_g, duty_b;
  logic [NUM_REQ-1:0]          grant;
  logic                        busy;
  logic                        LED_R, LED_G, LED_B;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] grant;
    int         len;
    int         r_low;
    int         g_low;
    int         b_low;
    int         idle;
  } exp_t;

  exp_t exp_q[$];

  rgb_led_scheduler #(
    .NUM_REQ(NUM_REQ), .PWM_BITS(PWM_BITS), .SLOT_CYCLES(SLOT_CYCLES),
    .GAP_CYCLES(GAP_CYCLES), .HB_BIT(HB_BIT)
  ) dut (
    .clk(clk), .rst(rst), .req(req),
    .duty_r(duty_r), .duty_g(duty_g), .duty_b(duty_b),
    .grant(grant), .busy(busy),
    .LED_R(LED_R), .LED_G(LED_G), .LED_B(LED_B)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic rst_v, input logic [3:0] req_v);
    rst = rst_v;
    req = req_v;
  endtask

  task automatic setDuty(input int lane, input int r, input int g, input int b);
    duty_r[lane*PWM_BITS +: PWM_BITS] = PWM_BITS'(r);
    duty_g[lane*PWM_BITS +: PWM_BITS] = PWM_BITS'(g);
    duty_b[lane*PWM_BITS +: PWM_BITS] = PWM_BITS'(b);
  endtask

  task automatic pushExp(input logic [3:0] g, input int len, input int r, input int gl,
                         input int b, input int idle);
    exp_t e;
    e.grant = g; e.len = len; e.r_low = r; e.g_low = gl; e.b_low = b; e.idle = idle;
    exp_q.push_back(e);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: LEDs observed at a negedge reflect the state of the previous cycle,
  // so a slot's PWM window is every sample whose previous grant was non-zero.
  logic [3:0] prev_grant, slot_grant;
  logic       prev_busy;
  int slot_len, r_low, g_low, b_low, idle_cnt, slot_idle, gap_len, gap_bad;

  always @(negedge clk) begin
    if (rst) begin
      prev_grant = '0; prev_busy = 1'b0; slot_grant = '0;
      slot_len = 0; r_low = 0; g_low = 0; b_low = 0;
      idle_cnt = 0; slot_idle = 0; gap_len = 0; gap_bad = 0;
    end else begin
      if (prev_grant != 0) begin
        slot_len++;
        if (!LED_R) r_low++;
        if (!LED_G) g_low++;
        if (!LED_B) b_low++;
      end
      if (grant != 0 && prev_grant == 0) begin
        slot_grant = grant;
        slot_idle  = idle_cnt;
        idle_cnt   = 0;
      end
      if (grant == 0 && prev_grant != 0) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_slot_grant", int'(slot_grant), 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          checkOutput("slot_grant", int'(slot_grant), int'(e.grant));
          checkOutput("slot_len", slot_len, e.len);
          checkOutput("slot_red_low", r_low, e.r_low);
          checkOutput("slot_green_low", g_low, e.g_low);
          checkOutput("slot_blue_low", b_low, e.b_low);
          checkOutput("idle_before_slot", slot_idle, e.idle);
        end
        slot_len = 0; r_low = 0; g_low = 0; b_low = 0;
      end
      if (busy && grant == 0) begin
        gap_len++;
        if (prev_grant == 0 && {LED_R, LED_G, LED_B} != 3'b111) gap_bad++;
      end
      if (!busy) begin
        if (prev_busy && prev_grant == 0) begin
          checkOutput("gap_len", gap_len, GAP_CYCLES);
          checkOutput("gap_led_lit", gap_bad, 0);
          gap_len = 0; gap_bad = 0;
        end
        idle_cnt++;
      end
      prev_grant = grant;
      prev_busy  = busy;
    end
  end

  initial begin
    int exp_g;
    duty_r = '0; duty_g = '0; duty_b = '0;
    applyStimulus(1'b1, 4'b1111);
    setDuty(0, 15, 8, 0);
    setDuty(1, 1, 0, 7);
    setDuty(2, 15, 8, 0);
    setDuty(3, 4, 12, 15);

    for (int i = 0; i < 3; i++) begin
      waitCycles(1);
      checkOutput("reset_grant", int'(grant), 0);
      checkOutput("reset_busy", int'(busy), 0);
      checkOutput("reset_leds", int'({LED_R, LED_G, LED_B}), 7);
    end

    // All four requesting: round-robin 0,1,2,3,0
    pushExp(4'b0001, 16, 15, 8, 0, 1);
    pushExp(4'b0010, 16, 1, 0, 7, 1);
    pushExp(4'b0100, 16, 15, 8, 0, 1);
    pushExp(4'b1000, 16, 4, 12, 15, 1);
    pushExp(4'b0001, 16, 15, 8, 0, 1);
    applyStimulus(1'b0, 4'b1111);
    waitCycles(1);
    checkOutput("first_grant_after_reset", int'(grant), 1);
    waitCycles(100);

    // Lone requester on lane 2 is re-granted after each gap
    applyStimulus(1'b0, 4'b0100);
    pushExp(4'b0100, 16, 15, 8, 0, 1);
    pushExp(4'b0100, 16, 15, 8, 0, 1);
    waitCycles(42);

    // Lane 3 with a mid-slot duty change, then lane 0 dropping after 5 cycles
    applyStimulus(1'b0, 4'b1001);
    setDuty(3, 15, 8, 3);
    setDuty(0, 15, 12, 0);
    pushExp(4'b1000, 16, 15, 8, 3, 1);
    pushExp(4'b0001, 5, 5, 3, 0, 1);
    pushExp(4'b0010, 16, 1, 0, 7, 1);
    waitCycles(9);
    setDuty(3, 0, 0, 0);
    waitCycles(21);
    applyStimulus(1'b0, 4'b1010);
    waitCycles(23);

    // Reset in the middle of the gap
    applyStimulus(1'b1, 4'b0000);
    waitCycles(1);
    checkOutput("gap_reset_grant", int'(grant), 0);
    checkOutput("gap_reset_busy", int'(busy), 0);
    checkOutput("gap_reset_leds", int'({LED_R, LED_G, LED_B}), 7);
    waitCycles(1);
    applyStimulus(1'b0, 4'b0000);
    pushExp(4'b0010, 16, 1, 0, 7, 17);
    for (int k = 0; k < 16; k++) begin
      waitCycles(1);
`ifdef RGB_LED_SCHED_HEARTBEAT_EN
      exp_g = ((k & 8) != 0) ? 0 : 1;
`else
      exp_g = 1;
`endif
      checkOutput("idle_led_g", int'(LED_G), exp_g);
      checkOutput("idle_led_rb", int'({LED_R, LED_B}), 3);
    end
    applyStimulus(1'b0, 4'b0110);
    waitCycles(17);
    applyStimulus(1'b0, 4'b0000);
    waitCycles(9);

    checkOutput("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
